fifo_read_packer: RTL and testbench
===================================

Name: fifo_read_packer

Overview:
- Read-side consumer of the async FIFO, clocked in the read domain.
- Pops bytes from the FIFO read port (readData/empty/rinc) and packs BYTES_PER_WORD consecutive bytes into one wide word, little-endian (first byte in the lowest lane).
- Presents each word on a valid/ready output with per-lane keep bits. A flush request emits a partially filled word.
- Includes a free-running count of output words.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (byte lane width).
- BYTES_PER_WORD, 4, lanes per output word; must be ≥2. Index width is clog2(BYTES_PER_WORD).
- COUNT_WIDTH, 16, width of word_count.

Ports:
- rclk  input  1  read-domain clock; all state updates on the rising edge.
- rrst  input  1  asynchronous, active-high reset.
- empty  input  1  FIFO empty flag. When 0, readData holds the head entry (first-word-fall-through).
- readData  input  DATA_WIDTH  FIFO head entry.
- rinc  output  1  pop strobe to the FIFO; combinational.
- flush  input  1  single-cycle request to emit the partial word.
- out_data  output  DATA_WIDTH*BYTES_PER_WORD  packed word; lane k is bits [k*DW +: DW].
- out_keep  output  BYTES_PER_WORD  lane-valid mask, bit k marks lane k.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.
- word_count  output  COUNT_WIDTH  number of completed output handshakes; wraps.

Behaviour:
- Reset (rrst=1, asynchronous):
  - out_valid=0, out_data=0, out_keep=0, word_count=0.
  - Accumulator lanes = 0, idx=0, flush_pending=0.
  - rinc=0 while rrst=1.
  - Bytes already popped into the accumulator are discarded.
- Internal state:
  - Accumulator register acc (BYTES_PER_WORD lanes), fill index idx, and flag flush_pending.
  - Output slot register (out_data/out_keep/out_valid).
- Definitions:
  - slot_free = !out_valid || out_ready.
  - completing = (idx == BYTES_PER_WORD-1).
- Pop rule: rinc = !rrst && !empty && !flush_pending && !(completing && !slot_free).
  - rinc is never 1 when empty=1.
- On rinc=1:
  - readData is written to acc lane idx.
  - If not completing: idx increments.
  - If completing: the full word {readData, acc lanes N-2..0} loads the output slot; out_keep = all ones, out_valid=1 next cycle, idx=0, acc cleared.
- Latency: the word is visible on out_data one rclk after the pop of its last byte.
- Throughput: one byte per cycle sustained with out_ready=1. No bubble at word boundaries; a pop completing a word may coincide with the handshake of the previous word.
- Handshake:
  - The transfer occurs when out_valid && out_ready at the rising edge; word_count increments by 1 (wraps).
  - If no new word loads that edge, out_valid goes to 0.
  - While out_valid=1 && out_ready=0, out_data and out_keep are stable.
- Flush:
  - flush=1 at an edge sets flush_pending (no effect if already set).
  - While flush_pending=1, rinc=0.
  - If idx==0: flush_pending clears next edge and no word is emitted.
  - Else, at the first edge with slot_free:
    - out_data = acc with unfilled lanes 0.
    - out_keep = lanes 0..idx-1 set.
    - out_valid=1, idx=0, acc cleared, flush_pending cleared.
- Simultaneous events:
  - If flush=1 in the same cycle as a completing pop, the pop completes normally. The pending flush then sees idx=0 and clears without emitting.
  - flush during backpressure waits; no bytes are popped meanwhile.
- State summary:
  - FILL: idx < N-1, or slot free.
  - STALL: completing && !slot_free, rinc held 0.
  - FLUSH: flush_pending.
  - All transitions are as above.

Test Plan:
- Directed stream, no backpressure:
  - Stimulus: release reset; FIFO head presents 0x12, 0x13, 0x14, 0x15 with empty=0; out_ready=1.
  - Required: rinc high 4 consecutive cycles; next cycle out_valid=1, out_data=0x15141312, out_keep=4'hF; word_count=1 after the handshake.
- Backpressure:
  - Stimulus: bytes 0x21..0x28 available; out_ready=0.
  - Required: out_data=0x24232221 held stable; bytes 0x25, 0x26, 0x27 popped, then rinc=0 with idx=3.
  - Stimulus: raise out_ready.
  - Required: 0x28 popped in the handshake cycle; next word 0x28272625 with no idle cycle.
- Partial flush:
  - Stimulus: pop 0x29, 0x30; then empty=1; pulse flush.
  - Required: out_data=0x00003029, out_keep=4'b0011, out_valid=1 one cycle after flush_pending is set; idx returns to 0.
- Empty flush:
  - Stimulus: flush pulse with idx=0.
  - Required: no out_valid; flush_pending clears next edge; rinc blocked for exactly that cycle.
- Empty gaps:
  - Stimulus: toggle empty randomly over 40 bytes with incrementing values.
  - Required: rinc never 1 while empty=1; 10 words out in order with correct byte lanes.
- Reset mid-operation:
  - Stimulus: assert rrst asynchronously, mid-cycle, with out_valid=1 and idx=2.
  - Required: out_valid, out_keep, out_data and word_count go to 0 immediately; after release the first word starts at lane 0.

Source files
------------

// File: rtl/fifo_read_packer_if.sv
// rtl/fifo_read_packer_if.sv - FIFO read port, flush request and packed-word stream bundle
//
// Purpose: groups the FIFO read-side handshake (empty/readData/rinc), the
// flush request and the packed output word stream (out_data/out_keep/
// out_valid/out_ready) of fifo_read_packer.
// Modports:
//   master - the packer: drives rinc and out_*, samples empty/readData/flush/out_ready
//   slave  - the environment (FIFO + downstream consumer)
interface fifo_read_packer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4
);
  logic                                 empty;
  logic [DATA_WIDTH-1:0]                readData;
  logic                                 rinc;
  logic                                 flush;
  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data;
  logic [BYTES_PER_WORD-1:0]            out_keep;
  logic                                 out_valid;
  logic                                 out_ready;

  modport master (
    input  empty, readData, flush, out_ready,
    output rinc, out_data, out_keep, out_valid
  );

  modport slave (
    output empty, readData, flush, out_ready,
    input  rinc, out_data, out_keep, out_valid
  );
endinterface

// File: rtl/fifo_read_packer.sv
// rtl/fifo_read_packer.sv - packs FIFO bytes little-endian into wide words with flush
//
// Purpose: pops entries from a first-word-fall-through FIFO read port and
// packs BYTES_PER_WORD of them into one word (first byte in lane 0). A flush
// request emits a partially filled word with a lane-valid mask.
// Ports:
//   rclk       - read-domain clock
//   rrst       - asynchronous active-high reset
//   bus        - fifo_read_packer_if.master: empty/readData in, rinc out,
//                flush in, out_data/out_keep/out_valid out, out_ready in
//   word_count - count of completed output handshakes, wraps
module fifo_read_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   rclk,
  input  logic                   rrst,
  fifo_read_packer_if.master     bus,
  output logic [COUNT_WIDTH-1:0] word_count
);
  localparam int DW = DATA_WIDTH;
  localparam int N  = BYTES_PER_WORD;
  localparam int IW = $clog2(BYTES_PER_WORD);
  localparam int WW = DW * N;

  logic [WW-1:0]          acc, acc_n;
  logic [IW-1:0]          idx, idx_n;
  logic                   flush_pending, flush_pending_n;
  logic [WW-1:0]          data_q, data_n;
  logic [N-1:0]           keep_q, keep_n;
  logic                   valid_q, valid_n;
  logic [COUNT_WIDTH-1:0] count_n;

  logic                   slot_free;
  logic                   completing;
  logic                   pop;
  logic [N-1:0]           lane_mask;

  assign slot_free  = !valid_q || bus.out_ready;
  assign completing = (idx == IW'(N - 1));

  // Lanes below the fill index hold popped bytes.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < N; k++) begin
      lane_mask[k] = (k < int'(idx));
    end
  end

  // State register
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      acc           <= '0;
      idx           <= '0;
      flush_pending <= 1'b0;
      data_q        <= '0;
      keep_q        <= '0;
      valid_q       <= 1'b0;
      word_count    <= '0;
    end else begin
      acc           <= acc_n;
      idx           <= idx_n;
      flush_pending <= flush_pending_n;
      data_q        <= data_n;
      keep_q        <= keep_n;
      valid_q       <= valid_n;
      word_count    <= count_n;
    end
  end

  // Next-state logic
  always_comb begin
    acc_n           = acc;
    idx_n           = idx;
    flush_pending_n = flush_pending;
    data_n          = data_q;
    keep_n          = keep_q;
    valid_n         = valid_q;
    count_n         = word_count;

    if (valid_q && bus.out_ready) begin
      valid_n = 1'b0;
      count_n = word_count + COUNT_WIDTH'(1);
    end

    if (pop) begin
      if (completing) begin
        // The last byte bypasses acc straight into the slot, so a word
        // boundary costs no extra cycle.
        data_n = acc;
        data_n[(N-1)*DW +: DW] = bus.readData;
        keep_n  = '1;
        valid_n = 1'b1;
        idx_n   = '0;
        acc_n   = '0;
      end else begin
        acc_n[int'(idx)*DW +: DW] = bus.readData;
        idx_n = idx + IW'(1);
      end
    end

    // pop is blocked while a flush is pending, so the two branches never
    // both load the slot in one cycle.
    if (!flush_pending) begin
      flush_pending_n = bus.flush;
    end else if (idx == '0) begin
      flush_pending_n = 1'b0;
    end else if (slot_free) begin
      // acc lanes above idx are already zero because acc is cleared on
      // every emit.
      data_n          = acc;
      keep_n          = lane_mask;
      valid_n         = 1'b1;
      idx_n           = '0;
      acc_n           = '0;
      flush_pending_n = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    pop = !rrst && !bus.empty && !flush_pending && !(completing && !slot_free);
  end

  assign bus.rinc      = pop;
  assign bus.out_data  = data_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_fifo_read_packer.sv
// tb/tb_fifo_read_packer.sv - self-checking bench for fifo_read_packer
module tb_fifo_read_packer;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int CW = 16;

  logic          rclk;
  logic          rrst;
  logic [CW-1:0] word_count;

  fifo_read_packer_if #(.DATA_WIDTH(DW), .BYTES_PER_WORD(N)) bus ();

  fifo_read_packer #(.DATA_WIDTH(DW), .BYTES_PER_WORD(N), .COUNT_WIDTH(CW)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .bus        (bus),
    .word_count (word_count)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic        empty;
    logic [7:0]  rd;
    logic        rdy;
    logic        fl;
    logic        exp_rinc;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[$];
  int   compared;
  int   mismatched;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [7:0] rd, input logic rdy, input logic fl,
                     input logic xr, input logic xv, input logic [31:0] xd,
                     input logic [3:0] xk, input logic [15:0] xc);
    vec_t v;
    v.empty = e; v.rd = rd; v.rdy = rdy; v.fl = fl;
    v.exp_rinc = xr; v.exp_valid = xv; v.exp_data = xd; v.exp_keep = xk; v.exp_count = xc;
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic e, input logic [7:0] rd, input logic rdy, input logic fl);
    @(negedge rclk);
    bus.empty = e; bus.readData = rd; bus.out_ready = rdy; bus.flush = fl;
    #1;
  endtask

  logic [7:0]  byteq[$];
  logic [31:0] expq[$];
  logic [31:0] held;
  logic        was_stalled;
  int          nb, got, viol;

  initial begin
    compared = 0; mismatched = 0;
    rrst = 1'b1;
    bus.empty = 1'b0; bus.readData = 8'h12; bus.out_ready = 1'b1; bus.flush = 1'b0;

    // Reset state
    @(negedge rclk); #1;
    check("reset_rinc", bus.rinc, 0);
    check("reset_valid", bus.out_valid, 0);
    check("reset_data", bus.out_data, 0);
    check("reset_keep", bus.out_keep, 0);
    check("reset_count", word_count, 0);
    @(negedge rclk);
    rrst = 1'b0; bus.empty = 1'b1;

    // empty rd rdy fl | rinc valid data keep count
    add(0, 8'h12, 1, 0, 1, 0, 0, 0, 0);
    add(0, 8'h13, 1, 0, 1, 0, 0, 0, 0);
    add(0, 8'h14, 1, 0, 1, 0, 0, 0, 0);
    add(0, 8'h15, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h00, 1, 0, 0, 1, 32'h15141312, 4'hF, 0);
    // backpressure
    add(0, 8'h21, 0, 0, 1, 0, 0, 0, 1);
    add(0, 8'h22, 0, 0, 1, 0, 0, 0, 1);
    add(0, 8'h23, 0, 0, 1, 0, 0, 0, 1);
    add(0, 8'h24, 0, 0, 1, 0, 0, 0, 1);
    add(0, 8'h25, 0, 0, 1, 1, 32'h24232221, 4'hF, 1);
    add(0, 8'h26, 0, 0, 1, 1, 32'h24232221, 4'hF, 1);
    add(0, 8'h27, 0, 0, 1, 1, 32'h24232221, 4'hF, 1);
    add(0, 8'h28, 0, 0, 0, 1, 32'h24232221, 4'hF, 1);
    add(0, 8'h28, 0, 0, 0, 1, 32'h24232221, 4'hF, 1);
    add(0, 8'h28, 1, 0, 1, 1, 32'h24232221, 4'hF, 1);
    add(0, 8'h29, 1, 0, 1, 1, 32'h28272625, 4'hF, 2);
    // partial flush
    add(0, 8'h30, 1, 0, 1, 0, 0, 0, 3);
    add(1, 8'h00, 1, 1, 0, 0, 0, 0, 3);
    add(1, 8'h00, 1, 0, 0, 0, 0, 0, 3);
    add(1, 8'h00, 1, 0, 0, 1, 32'h00003029, 4'h3, 3);
    // flush with idx=0
    add(1, 8'h00, 1, 1, 0, 0, 0, 0, 4);
    add(0, 8'h40, 1, 0, 0, 0, 0, 0, 4);
    add(0, 8'h40, 1, 0, 1, 0, 0, 0, 4);
    add(1, 8'h00, 1, 0, 0, 0, 0, 0, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].empty, vecs[i].rd, vecs[i].rdy, vecs[i].fl);
      check($sformatf("vec%0d_rinc", i), bus.rinc, vecs[i].exp_rinc);
      check($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_count", i), word_count, vecs[i].exp_count);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_data);
        check($sformatf("vec%0d_keep", i), bus.out_keep, vecs[i].exp_keep);
      end
    end

    // Asynchronous reset mid-cycle with a held word and idx=2
    cyc(0, 8'h41, 0, 0);
    cyc(0, 8'h42, 0, 0);
    cyc(0, 8'h43, 0, 0);
    cyc(0, 8'h44, 0, 0);
    check("pre_reset_rinc", bus.rinc, 1);
    check("pre_reset_data", bus.out_data, 32'h43424140);
    cyc(0, 8'h45, 0, 0);
    cyc(1, 8'h00, 0, 0);
    check("pre_reset_valid", bus.out_valid, 1);
    bus.empty = 1'b0;
    #1;
    rrst = 1'b1;
    #1;
    check("async_reset_valid", bus.out_valid, 0);
    check("async_reset_data", bus.out_data, 0);
    check("async_reset_keep", bus.out_keep, 0);
    check("async_reset_count", word_count, 0);
    check("async_reset_rinc", bus.rinc, 0);
    @(negedge rclk);
    rrst = 1'b0; bus.empty = 1'b1;
    cyc(0, 8'h60, 1, 0);
    cyc(0, 8'h61, 1, 0);
    cyc(0, 8'h62, 1, 0);
    cyc(0, 8'h63, 1, 0);
    cyc(1, 8'h00, 1, 0);
    check("post_reset_valid", bus.out_valid, 1);
    check("post_reset_data", bus.out_data, 32'h63626160);
    check("post_reset_keep", bus.out_keep, 4'hF);

    // Randomized empty gaps and backpressure against a queue model
    @(negedge rclk);
    rrst = 1'b1;
    @(negedge rclk);
    rrst = 1'b0;
    nb = 0; got = 0; viol = 0; was_stalled = 1'b0; held = '0;
    for (int c = 0; c < 3000 && got < 10; c++) begin
      @(negedge rclk);
      bus.empty     = (nb >= 40) ? 1'b1 : ($urandom_range(0, 2) == 0);
      bus.readData  = bus.empty ? 8'($urandom) : 8'(8'h80 + nb);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = 1'b0;
      #1;
      if (bus.rinc && bus.empty) viol++;
      if (was_stalled) check("rnd_stable", bus.out_data, held);
      if (bus.out_valid && bus.out_ready) begin
        check("rnd_word_expected", (expq.size() > 0), 1);
        if (expq.size() > 0) check("rnd_word", bus.out_data, expq.pop_front());
        check("rnd_keep", bus.out_keep, 4'hF);
        got++;
      end
      was_stalled = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      if (bus.rinc) begin
        byteq.push_back(bus.readData);
        nb++;
        if (byteq.size() == N) begin
          expq.push_back({byteq[3], byteq[2], byteq[1], byteq[0]});
          byteq.delete();
        end
      end
    end
    @(negedge rclk); #1;
    check("rnd_words", got, 10);
    check("rnd_bytes", nb, 40);
    check("rnd_rinc_while_empty", viol, 0);
    check("rnd_count", word_count, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
